pic_lite: RTL and testbench

PIC_LITE -- requirements
Module: pic_lite

---
 rtl/pic_pkg.sv | 8 +
 rtl/pic_priority.sv | 13 +
 rtl/pic_lite.sv | 84 ++++++++
 tb/tb_pic_lite.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: register offsets, command bit positions and FSM states for pic_lite
package pic_pkg;
  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_MASK = 1'b1;
  localparam int CMD_NSEOI = 7;
  localparam int CMD_SEOI = 6;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/pic_priority.sv
// pic_priority: 8-bit fixed-priority encoder, bit 0 highest, with valid flag
module pic_priority (
  input  logic [7:0] req_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);
  // scan from lowest priority upward so the highest-priority set bit wins
  always_comb begin
    idx_o = 3'd0;
    for (int i = 7; i >= 0; i--) idx_o = req_i[i] ? 3'(i) : idx_o;
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/pic_lite.sv
// pic_lite: 8-line fixed-priority interrupt controller; PIC_AUTO_EOI_EN enables the AEOI mode bit
module pic_lite
  import pic_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr_en,
  input  logic        addr,
  input  logic [1:0]  bytesel,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        ack,
  input  logic [7:0]  irq_lines,
  output logic        intr,
  input  logic        inta,
  output logic [7:0]  irq
);
  logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, edge_q, irq_q, win, eoi_clr;
  logic [15:0] data_out_q;
  logic ack_q, busy_q, inta_q, intr_q, aeoi, pv, sv, access, take, cmd_wr, unused_bits;
  logic [2:0] pidx, sidx;
  state_t state_q;
  pic_priority u_pend (.req_i(irr_q & ~imr_q), .valid_o(pv), .idx_o(pidx));
  pic_priority u_serv (.req_i(isr_q), .valid_o(sv), .idx_o(sidx));
  assign access = cs & ~busy_q;
  assign cmd_wr = access & wr_en & (addr == ADDR_STATUS) & bytesel[0];
  assign take = (state_q == IDLE) & inta & ~inta_q;
  assign win = (take & pv) ? 8'h01 << pidx : 8'h00;
  assign eoi_clr = ~cmd_wr ? 8'h00 :
                   data_in[CMD_NSEOI] ? (sv ? 8'h01 << sidx : 8'h00) :
                   data_in[CMD_SEOI] ? 8'h01 << data_in[2:0] : 8'h00;
  assign irr_d = (irr_q & ~win) | (irq_lines & ~edge_q);
  assign isr_d = (isr_q & ~eoi_clr) | (aeoi ? 8'h00 : win);
  assign unused_bits = ^{data_in[15:8], bytesel[1]};
`ifdef PIC_AUTO_EOI_EN
  logic aeoi_q;
  // auto-EOI mode bit lives in byte lane 1 of the mask register
  always_ff @(posedge clk)
    aeoi_q <= reset ? 1'b0 : (access & wr_en & (addr == ADDR_MASK) & bytesel[1]) ? data_in[8] : aeoi_q;
  assign aeoi = aeoi_q;
`else
  assign aeoi = 1'b0;
`endif
  // port bus: one ack per cs assertion, read data only in the ack cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      ack_q <= 1'b0;
      data_out_q <= '0;
      imr_q <= 8'hFF;
    end else begin
      busy_q <= cs;
      ack_q <= access;
      data_out_q <= (access & ~wr_en) ? (addr == ADDR_MASK ? {7'b0, aeoi, imr_q} : {isr_q, irr_q}) : 16'h0000;
      imr_q <= (access & wr_en & (addr == ADDR_MASK) & bytesel[0]) ? data_in[7:0] : imr_q;
    end
  end
  // request/service registers and the acknowledge FSM
  always_ff @(posedge clk) begin
    inta_q <= inta;
    if (reset) begin
      irr_q <= '0;
      isr_q <= '0;
      edge_q <= irq_lines;
      irq_q <= '0;
      intr_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      irr_q <= irr_d;
      isr_q <= isr_d;
      edge_q <= irq_lines;
      intr_q <= pv & (~sv | (pidx < sidx));
      irq_q <= take ? VECTOR_BASE + (pv ? {5'b0, pidx} : 8'd7) : irq_q;
      state_q <= take ? HOLD : (state_q == HOLD & ~inta) ? IDLE : state_q;
    end
  end
  assign data_out = data_out_q;
  assign ack = ack_q;
  assign intr = intr_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_pic_lite.sv
// tb_pic_lite: table-driven, directed and randomized checks of pic_lite against a behavioural model
module tb_pic_lite;
  logic clk = 0, reset = 1, cs = 0, wr_en = 0, addr = 0, inta = 0, intr, ack;
  logic [1:0] bytesel = 0;
  logic [15:0] data_in = 0, data_out;
  logic [7:0] irq_lines = 0, irq;
  int total = 0, passed = 0;

  pic_lite dut (.clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .addr(addr), .bytesel(bytesel),
                .data_in(data_in), .data_out(data_out), .ack(ack), .irq_lines(irq_lines),
                .intr(intr), .inta(inta), .irq(irq));

  always #5 clk = ~clk;

  logic [7:0] m_irr, m_isr, m_imr, m_prev, m_irq;
  logic m_aeoi, m_hold, m_inta_prev, m_busy, m_ack, m_intr;
  logic [15:0] m_dout;

  function automatic int first_set(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic model_update();
    int p, s;
    logic tk, acc;
    logic [7:0] irr_n, isr_n;
    if (reset) begin
      m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_aeoi = 0; m_irq = 0; m_intr = 0;
      m_hold = 0; m_busy = 0; m_ack = 0; m_dout = 0;
    end else begin
      p = first_set(m_irr & ~m_imr);
      s = first_set(m_isr);
      tk = !m_hold && inta && !m_inta_prev;
      acc = cs && !m_busy;
      irr_n = m_irr;
      isr_n = m_isr;
      if (acc && wr_en && !addr && bytesel[0]) begin
        if (data_in[7]) begin
          if (s < 8) isr_n[s] = 0;
        end else if (data_in[6]) isr_n[data_in[2:0]] = 0;
      end
      if (tk) begin
        m_irq = 8'h08 + 8'(p < 8 ? p : 7);
        if (p < 8) begin
          irr_n[p] = 0;
          if (!m_aeoi) isr_n[p] = 1;
        end
        m_hold = 1;
      end else if (m_hold && !inta) m_hold = 0;
      for (int i = 0; i < 8; i++) if (irq_lines[i] && !m_prev[i]) irr_n[i] = 1;
      m_dout = (acc && !wr_en) ? (addr ? {7'b0, m_aeoi, m_imr} : {m_isr, m_irr}) : 16'h0;
      m_intr = (p < 8) && (p < s);
      if (acc && wr_en && addr && bytesel[0]) m_imr = data_in[7:0];
`ifdef PIC_AUTO_EOI_EN
      if (acc && wr_en && addr && bytesel[1]) m_aeoi = data_in[8];
`endif
      m_ack = acc;
      m_busy = cs;
      m_irr = irr_n;
      m_isr = isr_n;
    end
    m_prev = irq_lines;
    m_inta_prev = inta;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_write(logic a, logic [1:0] bs, logic [15:0] d);
    cs = 1; wr_en = 1; addr = a; bytesel = bs; data_in = d;
    step();
    cs = 0; wr_en = 0;
    step();
  endtask

  task automatic bus_read(logic a, output logic [15:0] d);
    cs = 1; wr_en = 0; addr = a;
    step();
    d = data_out;
    cs = 0;
    step();
  endtask

  task automatic read_check(string name, logic a, logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic pulse(logic [7:0] m);
    irq_lines = irq_lines | m;
    step();
    irq_lines = irq_lines & ~m;
    step();
    step();
  endtask

  task automatic do_inta();
    inta = 1;
    step(); step();
    inta = 0;
    step(); step();
  endtask

  typedef struct {
    logic [1:0] bs;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
`ifdef PIC_AUTO_EOI_EN
    tbl = '{'{2'b01, 16'h00A5, 16'h00A5}, '{2'b11, 16'h015A, 16'h015A}, '{2'b10, 16'h00FF, 16'h005A},
            '{2'b00, 16'h01FF, 16'h005A}, '{2'b11, 16'h0100, 16'h0100}, '{2'b01, 16'h00FF, 16'h01FF}};
`else
    tbl = '{'{2'b01, 16'h00A5, 16'h00A5}, '{2'b11, 16'h015A, 16'h005A}, '{2'b10, 16'h00FF, 16'h005A},
            '{2'b00, 16'h01FF, 16'h005A}, '{2'b11, 16'h0100, 16'h0000}, '{2'b01, 16'h00FF, 16'h00FF}};
`endif
    @(negedge clk);
    step(); step();
    reset = 0;
    check("reset_intr", {15'b0, intr}, 16'h0);
    check("reset_irq", {8'h0, irq}, 16'h0);
    check("reset_ack", {15'b0, ack}, 16'h0);
    check("reset_dout", data_out, 16'h0);
    read_check("reset_mask", 1'b1, 16'h00FF);
    read_check("reset_status", 1'b0, 16'h0000);
    foreach (tbl[i]) begin
      bus_write(1'b1, tbl[i].bs, tbl[i].wdata);
      read_check($sformatf("mask_tbl%0d", i), 1'b1, tbl[i].exp);
    end
    // basic acknowledge of line 0
    bus_write(1'b1, 2'b11, 16'h00FE);
    pulse(8'h01);
    check("l0_intr", {15'b0, intr}, 16'h1);
    do_inta();
    check("l0_irq", {8'h0, irq}, 16'h0008);
    check("l0_intr_drop", {15'b0, intr}, 16'h0);
    read_check("l0_status", 1'b0, 16'h0100);
    bus_write(1'b0, 2'b01, 16'h0080);
    read_check("l0_eoi", 1'b0, 16'h0000);
    // lines 3 and 5 pending, served in priority order
    bus_write(1'b1, 2'b01, 16'h0000);
    pulse(8'h28);
    check("l35_intr", {15'b0, intr}, 16'h1);
    do_inta();
    check("l35_irq_a", {8'h0, irq}, 16'h000B);
    bus_write(1'b0, 2'b01, 16'h0080);
    check("l35_intr_b", {15'b0, intr}, 16'h1);
    do_inta();
    check("l35_irq_b", {8'h0, irq}, 16'h000D);
    bus_write(1'b0, 2'b01, 16'h0080);
    read_check("l35_status", 1'b0, 16'h0000);
    // nesting: lower priority blocked, higher priority preempts
    pulse(8'h20);
    do_inta();
    check("nest_irq5", {8'h0, irq}, 16'h000D);
    pulse(8'h40);
    check("nest_l6_blocked", {15'b0, intr}, 16'h0);
    pulse(8'h04);
    check("nest_l2_intr", {15'b0, intr}, 16'h1);
    do_inta();
    check("nest_irq2", {8'h0, irq}, 16'h000A);
    bus_write(1'b0, 2'b01, 16'h0080);
    check("nest_still_blocked", {15'b0, intr}, 16'h0);
    bus_write(1'b0, 2'b01, 16'h0080);
    check("nest_l6_release", {15'b0, intr}, 16'h1);
    do_inta();
    check("nest_irq6", {8'h0, irq}, 16'h000E);
    bus_write(1'b0, 2'b01, 16'h0080);
    // spurious acknowledge
    pulse(8'h08);
    do_inta();
    do_inta();
    check("spur_irq", {8'h0, irq}, 16'h000F);
    read_check("spur_status", 1'b0, 16'h0800);
    bus_write(1'b0, 2'b01, 16'h0080);
    // status read timing with masked pending request
    pulse(8'h04);
    do_inta();
    bus_write(1'b1, 2'b01, 16'h00FF);
    pulse(8'h10);
    check("mask_intr", {15'b0, intr}, 16'h0);
    cs = 1; wr_en = 0; addr = 0;
    step();
    check("rd_ack", {15'b0, ack}, 16'h1);
    check("rd_data", data_out, 16'h0410);
    step();
    check("rd_ack_once", {15'b0, ack}, 16'h0);
    check("rd_data_zero", data_out, 16'h0000);
    cs = 0;
    step();
    bus_write(1'b1, 2'b01, 16'h0000);
    bus_write(1'b0, 2'b01, 16'h0080);
    check("mask_retained", {15'b0, intr}, 16'h1);
    do_inta();
    check("mask_irq4", {8'h0, irq}, 16'h000C);
    bus_write(1'b0, 2'b01, 16'h0080);
    // new edge coincides with acknowledge clearing the same IRR bit
    pulse(8'h02);
    irq_lines = 8'h02; inta = 1;
    step();
    irq_lines = 0; inta = 0;
    step(); step();
    check("edge_clr_irq", {8'h0, irq}, 16'h0009);
    read_check("edge_clr_status", 1'b0, 16'h0202);
    // specific EOI and acknowledge on the same ISR bit
    cs = 1; wr_en = 1; addr = 0; bytesel = 2'b01; data_in = 16'h0041; inta = 1;
    step();
    cs = 0; wr_en = 0; inta = 0;
    step(); step();
    read_check("eoi_ack_status", 1'b0, 16'h0200);
    bus_write(1'b0, 2'b01, 16'h0080);
    read_check("eoi_clean", 1'b0, 16'h0000);
    // reset while in HOLD needs a fresh inta edge
    inta = 1;
    step();
    reset = 1;
    step();
    reset = 0;
    step();
    check("hold_reset_irq", {8'h0, irq}, 16'h0000);
    bus_write(1'b1, 2'b01, 16'h0000);
    pulse(8'h01);
    check("hold_no_edge_irq", {8'h0, irq}, 16'h0000);
    check("hold_intr", {15'b0, intr}, 16'h1);
    inta = 0;
    step();
    inta = 1;
    step();
    check("hold_fresh_irq", {8'h0, irq}, 16'h0008);
    inta = 0;
    step(); step();
    bus_write(1'b0, 2'b01, 16'h0080);
`ifdef PIC_AUTO_EOI_EN
    bus_write(1'b1, 2'b11, 16'h0100);
    pulse(8'h02);
    do_inta();
    check("aeoi_irq", {8'h0, irq}, 16'h0009);
    read_check("aeoi_status", 1'b0, 16'h0000);
    bus_write(1'b1, 2'b11, 16'h0000);
`endif
    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      cs = ($urandom_range(0, 2) == 0);
      wr_en = $urandom_range(0, 1);
      addr = $urandom_range(0, 1);
      bytesel = 2'($urandom_range(0, 3));
      data_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) irq_lines = irq_lines ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) inta = ~inta;
      step();
      check("rnd_intr", {15'b0, intr}, {15'b0, m_intr});
      check("rnd_irq", {8'h0, irq}, {8'h0, m_irq});
      check("rnd_ack", {15'b0, ack}, {15'b0, m_ack});
      check("rnd_dout", data_out, m_dout);
    end
    reset = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
